// File: rtl/lcd_timing_gen_p.sv
// Parametrised LCD panel timing generator: HSYNC/VSYNC/DE, active-area
// coordinates, line-prefetch request and frame counter, all registered.
module lcd_timing_gen_p #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FRONT  = 210,
    parameter int   H_SYNC   = 1,
    parameter int   H_BACK   = 45,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 22,
    parameter int   V_SYNC   = 1,
    parameter int   V_BACK   = 22,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PREFETCH = 16,
    localparam int  H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT,
    localparam int  V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT,
    localparam int  XW       = $clog2(H_ACTIVE),
    localparam int  YW       = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hd,
    output logic          vd,
    output logic          den,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic          line_req,
    output logic [YW-1:0] line_req_y,
    output logic [15:0]   frame_cnt
);

    // One extra bit of headroom so region end points equal to the total still fit.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] HS_END = HW'(H_SYNC);
    localparam logic [HW-1:0] HA0    = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] HA_END = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_REQ  = HW'(H_TOTAL - PREFETCH);
    localparam logic [VW-1:0] VS_END = VW'(V_SYNC);
    localparam logic [VW-1:0] VA0    = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] VA_END = VW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          hd_q, hd_d;
    logic          vd_q, vd_d;
    logic          den_q, den_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          frame_start_q, frame_start_d;
    logic          line_req_q, line_req_d;
    logic [YW-1:0] line_req_y_q, line_req_y_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          h_act_s, v_act_s, vn_act_s, hc_wrap_s, frame_top_s, req_hit_s;
    logic [HW-1:0] hc_nxt_s, hc_off_s;
    logic [VW-1:0] vc_nxt_s, vc_off_s, vn_off_s;

    // Region decode of the current counters and next-state computation.
    always_comb begin
        h_act_s     = (hc_q >= HA0) && (hc_q < HA_END);
        v_act_s     = (vc_q >= VA0) && (vc_q < VA_END);
        hc_wrap_s   = (hc_q == H_LAST);
        hc_nxt_s    = hc_wrap_s ? {HW{1'b0}} : hc_q + HW'(1);
        vc_nxt_s    = (vc_q == V_LAST) ? {VW{1'b0}} : vc_q + VW'(1);
        vn_act_s    = (vc_nxt_s >= VA0) && (vc_nxt_s < VA_END);
        hc_off_s    = hc_q - HA0;
        vc_off_s    = vc_q - VA0;
        vn_off_s    = vc_nxt_s - VA0;
        frame_top_s = (hc_q == {HW{1'b0}}) && (vc_q == {VW{1'b0}});
        req_hit_s   = (hc_q == H_REQ) && vn_act_s;

        if (en) begin
            hc_d          = hc_nxt_s;
            vc_d          = hc_wrap_s ? vc_nxt_s : vc_q;
            hd_d          = (hc_q < HS_END) ? HS_POL : ~HS_POL;
            vd_d          = (vc_q < VS_END) ? VS_POL : ~VS_POL;
            den_d         = h_act_s && v_act_s;
            x_d           = (h_act_s && v_act_s) ? hc_off_s[XW-1:0] : {XW{1'b0}};
            y_d           = (h_act_s && v_act_s) ? vc_off_s[YW-1:0] : {YW{1'b0}};
            frame_start_d = frame_top_s;
            line_req_d    = req_hit_s;
            line_req_y_d  = req_hit_s ? vn_off_s[YW-1:0] : {YW{1'b0}};
            frame_cnt_d   = frame_top_s ? frame_cnt_q + 16'd1 : frame_cnt_q;
        end else begin
            // Paused: levels hold, one-cycle pulses must not repeat.
            hc_d          = hc_q;
            vc_d          = vc_q;
            hd_d          = hd_q;
            vd_d          = vd_q;
            den_d         = den_q;
            x_d           = x_q;
            y_d           = y_q;
            frame_start_d = 1'b0;
            line_req_d    = 1'b0;
            line_req_y_d  = {YW{1'b0}};
            frame_cnt_d   = frame_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q          <= {HW{1'b0}};
            vc_q          <= {VW{1'b0}};
            hd_q          <= ~HS_POL;
            vd_q          <= ~VS_POL;
            den_q         <= 1'b0;
            x_q           <= {XW{1'b0}};
            y_q           <= {YW{1'b0}};
            frame_start_q <= 1'b0;
            line_req_q    <= 1'b0;
            line_req_y_q  <= {YW{1'b0}};
            frame_cnt_q   <= 16'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hd_q          <= hd_d;
            vd_q          <= vd_d;
            den_q         <= den_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            line_req_q    <= line_req_d;
            line_req_y_q  <= line_req_y_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hd          = hd_q;
    assign vd          = vd_q;
    assign den         = den_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign line_req    = line_req_q;
    assign line_req_y  = line_req_y_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_lcd_timing_gen_p.sv
// Directed bench for lcd_timing_gen_p on an 8x6 toy geometry, with a
// second instance at inverted sync polarity driven by the same stimulus.
module tb_lcd_timing_gen_p;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic       hd_a, vd_a, den_a, fs_a, lr_a;
    logic [1:0] x_a, y_a, lry_a;
    logic [15:0] fc_a;
    logic       hd_p, vd_p, den_p, fs_p, lr_p;
    logic [1:0] x_p, y_p, lry_p;
    logic [15:0] fc_p;

    lcd_timing_gen_p #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(2)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .hd(hd_a), .vd(vd_a), .den(den_a), .x(x_a), .y(y_a),
        .frame_start(fs_a), .line_req(lr_a), .line_req_y(lry_a),
        .frame_cnt(fc_a)
    );

    lcd_timing_gen_p #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(2)
    ) u_dut_pol (
        .clk(clk), .rst(rst), .en(en),
        .hd(hd_p), .vd(vd_p), .den(den_p), .x(x_p), .y(y_p),
        .frame_start(fs_p), .line_req(lr_p), .line_req_y(lry_p),
        .frame_cnt(fc_p)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int lr_cycles[$];
    int fs_count;
    int den_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs after the edge that decoded enabled-step index i.
    // Toy geometry: hc 0 = sync, 3..6 active; vc 0 = sync, 2..4 active.
    task automatic check_outputs(input int i, input bit pulses_on);
        int  hc;
        int  vc;
        bit  e_den;
        bit  e_lr;
        hc    = i % 8;
        vc    = (i / 8) % 6;
        e_den = (hc >= 3) && (hc <= 6) && (vc >= 2) && (vc <= 4);
        e_lr  = pulses_on && (hc == 6) && (vc >= 1) && (vc <= 3);
        chk("hd",          32'(hd_a),  (hc == 0) ? 32'd0 : 32'd1);
        chk("vd",          32'(vd_a),  (vc == 0) ? 32'd0 : 32'd1);
        chk("hd_pol",      32'(hd_p),  (hc == 0) ? 32'd1 : 32'd0);
        chk("vd_pol",      32'(vd_p),  (vc == 0) ? 32'd1 : 32'd0);
        chk("den",         32'(den_a), 32'(e_den));
        chk("den_pol",     32'(den_p), 32'(e_den));
        chk("x",           32'(x_a),   e_den ? 32'(hc - 3) : 32'd0);
        chk("y",           32'(y_a),   e_den ? 32'(vc - 2) : 32'd0);
        chk("x_pol",       32'(x_p),   e_den ? 32'(hc - 3) : 32'd0);
        chk("y_pol",       32'(y_p),   e_den ? 32'(vc - 2) : 32'd0);
        chk("frame_start", 32'(fs_a),  32'(pulses_on && (hc == 0) && (vc == 0)));
        chk("line_req",    32'(lr_a),  32'(e_lr));
        chk("line_req_y",  32'(lry_a), e_lr ? 32'(vc - 1) : 32'd0);
        chk("frame_cnt",   32'(fc_a),  32'((i / 48 + 1) % 65536));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hd"},  32'(hd_a),  32'd1);
        chk({tag, "_vd"},  32'(vd_a),  32'd1);
        chk({tag, "_hdp"}, 32'(hd_p),  32'd0);
        chk({tag, "_vdp"}, 32'(vd_p),  32'd0);
        chk({tag, "_den"}, 32'(den_a), 32'd0);
        chk({tag, "_x"},   32'(x_a),   32'd0);
        chk({tag, "_y"},   32'(y_a),   32'd0);
        chk({tag, "_fs"},  32'(fs_a),  32'd0);
        chk({tag, "_lr"},  32'(lr_a),  32'd0);
        chk({tag, "_lry"}, 32'(lry_a), 32'd0);
        chk({tag, "_fc"},  32'(fc_a),  32'd0);
    endtask

    // One clock with the given enable, then sample on the falling edge.
    task automatic step(input bit e);
        en = e;
        @(posedge clk);
        if (e) k++;
        @(negedge clk);
        check_outputs(k - 1, e);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Continuous frame after release.
        rst       = 1'b0;
        k         = 0;
        fs_count  = 0;
        den_count = 0;
        for (int c = 1; c <= 48; c++) begin
            step(1'b1);
            if (lr_a) lr_cycles.push_back(c);
            if (fs_a) fs_count++;
            if (den_a) den_count++;
        end
        chk("fs_pulses", 32'(fs_count), 32'd1);
        chk("den_cycles", 32'(den_count), 32'd12);
        chk("lr_pulses", 32'(lr_cycles.size()), 32'd3);
        if (lr_cycles.size() == 3) begin
            chk("lr_cyc0", 32'(lr_cycles[0]), 32'd15);
            chk("lr_cyc1", 32'(lr_cycles[1]), 32'd23);
            chk("lr_cyc2", 32'(lr_cycles[2]), 32'd31);
        end
        chk("fc_frame1", 32'(fc_a), 32'd1);

        // Enable toggling every other cycle.
        for (int i = 0; i < 96; i++) begin
            step((i % 2) == 0);
        end

        // Advance to the middle of the active area, then reset asynchronously.
        for (int i = 0; i < 48 && ((k - 1) % 48) != 29; i++) begin
            step(1'b1);
        end
        chk("pre_rst_den", 32'(den_a), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("async");
        repeat (3) @(negedge clk);
        check_reset("held");

        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 56; i++) begin
            step(1'b1);
        end
        chk("fc_restart", 32'(fc_a), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen_p.md
# lcd_timing_gen_p

Parametrised successor to the fixed-resolution LCD timing generator. It produces HSYNC, VSYNC and data-enable for the LTM panel, along with active-area pixel coordinates. It adds four features: programmable geometry and sync polarity, a clock-enable pause, a line-prefetch request that lets the processor fill the two-line colour buffer ahead of display, and a frame counter. It sits between the LCD pixel clock domain and the frame/line buffer, and drives the GPIO panel pins.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 210, horizontal front porch (cycles)
- H_SYNC, 1, horizontal sync width (cycles)
- H_BACK, 45, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 22, vertical front porch (lines)
- V_SYNC, 1, vertical sync width (lines)
- V_BACK, 22, vertical back porch (lines)
- HS_POL, 0, active level of hd
- VS_POL, 0, active level of vd
- PREFETCH, 16, cycles before line end at which line_req fires; legal range is 1 ≤ PREFETCH ≤ H_FRONT+H_SYNC+H_BACK
- Derived values:
  - H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT
  - V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT
  - XW = $clog2(H_ACTIVE)
  - YW = $clog2(V_ACTIVE)
- Ports:
  - clk  in  1  pixel clock; the single clock of the block
  - rst  in  1  asynchronous, active-high reset
  - en  in  1  clock enable; when low, all state freezes
  - hd  out  1  horizontal sync
  - vd  out  1  vertical sync
  - den  out  1  data enable, high for active pixels
  - x  out  XW  active-area column
  - y  out  YW  active-area row
  - frame_start  out  1  one-cycle pulse at the first cycle of each frame
  - line_req  out  1  one-cycle pulse requesting the next active line
  - line_req_y  out  YW  row index being requested; valid while line_req=1
  - frame_cnt  out  16  count of frames started

## Operation
- The block has one clock and an asynchronous active-high reset. Every output is registered.
- Internal counters:
  - hc runs 0..H_TOTAL-1.
  - vc runs 0..V_TOTAL-1 and advances when hc wraps from H_TOTAL-1 to 0.
  - vc wraps from V_TOTAL-1 to 0.
- Horizontal regions, by hc:
  - sync: [0, H_SYNC)
  - back porch: [H_SYNC, H_SYNC+H_BACK)
  - active: [HA0 = H_SYNC+H_BACK, HA0+H_ACTIVE)
  - front porch: the remainder of the line
- Vertical regions use the same layout on vc, with VA0 = V_SYNC+V_BACK.
- On each clk edge with en=1, the outputs load decode(hc,vc) and the counters advance. The decode is:
  - hd = HS_POL if hc is in sync, otherwise ~HS_POL.
  - vd = VS_POL if vc is in sync, otherwise ~VS_POL.
  - den = 1 when both hc and vc are active.
  - x = hc-HA0 and y = vc-VA0 when den=1; otherwise both are 0.
  - frame_start = 1 when hc=0 and vc=0; frame_cnt increments on the same edge and wraps from 0xFFFF to 0.
  - line_req = 1 when hc = H_TOTAL-PREFETCH and the next line, (vc+1) mod V_TOTAL, is active. In that case line_req_y = that line's row index; otherwise line_req_y = 0.
- When en=0, the counters and the hd/vd/den/x/y/frame_cnt registers hold their values. frame_start and line_req are forced to 0.
- Reset values: hc=0, vc=0, hd=~HS_POL, vd=~VS_POL, den=0, x=0, y=0, frame_start=0, line_req=0, line_req_y=0, frame_cnt=0.
- Reset mid-frame aborts the frame immediately (asynchronously). The first enabled edge after reset releases outputs decode(0,0): frame_start=1, with hd and vd both at their active levels.
- The line request for row 0 fires on line VA0-1. When VA0=0, it fires on line V_TOTAL-1 of the previous frame.

## Timing
- Outputs lag the counters by exactly one cycle. The relative timing between all outputs is exact, with no skew between den, x and y.
- The frame period is H_TOTAL×V_TOTAL enabled cycles.
- line_req leads the first den cycle of the requested row by exactly PREFETCH+HA0 enabled cycles.
- Pausing with en does not change any output-to-output relationship, measured in enabled cycles.

## Test plan
All scenarios use small parameters: H 4/1/1/2 (active/front/sync/back, giving H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PREFETCH=2, polarities 0. One frame is 48 cycles.
- Reset release then 48 enabled cycles:
  - frame_start is high on cycle 1 only.
  - hd is low on cycles 1, 9, 17, …
  - den is high for 4 cycles per line on lines 2–4, with x running 0,1,2,3.
  - frame_cnt=1.
- line_req check: pulses on cycles 15, 23 and 31 (hc=6, vc=1,2,3), with line_req_y = 0, 1, 2 respectively. Each pulse is 5 cycles before the corresponding den rise.
- en toggling every other cycle for 96 cycles: the output sequence equals the continuous-run sequence with every output duplicated. frame_start and line_req appear as single-cycle pulses only on enabled cycles.
- rst asserted at cycle 30 (mid-active) for 3 cycles: outputs go to reset values asynchronously. After release, the frame restarts from decode(0,0) and frame_cnt restarts at 1.
- Polarity HS_POL=1, VS_POL=1: hd and vd are the inversion of scenario 1. den, x and y are unchanged.
- Run 65537 frames (frame_cnt forced near its limit, or long sim): frame_cnt goes 0xFFFF→0 and then 1, with no glitch on frame_start.
